// File: rtl/expr_pkg.sv
// Shared constants and types for the streaming expression checker:
// ASCII codes, FSM states, error causes and the character-class bundle.
package expr_pkg;

    localparam logic [7:0] CH_0   = 8'd48;
    localparam logic [7:0] CH_9   = 8'd57;
    localparam logic [7:0] CH_MUL = 8'd42;
    localparam logic [7:0] CH_ADD = 8'd43;
    localparam logic [7:0] CH_SUB = 8'd45;
    localparam logic [7:0] CH_DIV = 8'd47;
    localparam logic [7:0] CH_LP  = 8'd40;
    localparam logic [7:0] CH_RP  = 8'd41;

    typedef enum logic [1:0] {
        S_OPND  = 2'd0,
        S_NUM   = 2'd1,
        S_CLOSE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        E_NONE    = 3'd0,
        E_BAD     = 3'd1,
        E_TOKEN   = 3'd2,
        E_DEPTH   = 3'd3,
        E_UNMATCH = 3'd4,
        E_LONG    = 3'd5
    } err_t;

    typedef struct packed {
        logic is_digit;
        logic is_op;
        logic is_lp;
        logic is_rp;
        logic is_bad;
    } cclass_t;

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier; '-' and '/' only count as operators
// when ALLOW_MINUS is set, otherwise they fall through to "bad".
module expr_char_class
    import expr_pkg::*;
#(
    parameter int ALLOW_MINUS = 1
) (
    input  logic [7:0] ch_i,
    output cclass_t    cls_o
);

    logic minus_ok;

    assign minus_ok = (ALLOW_MINUS != 0);

    always_comb begin
        cls_o          = '0;
        cls_o.is_digit = (ch_i >= CH_0) && (ch_i <= CH_9);
        cls_o.is_op    = (ch_i == CH_MUL) || (ch_i == CH_ADD) ||
                         (minus_ok && ((ch_i == CH_SUB) || (ch_i == CH_DIV)));
        cls_o.is_lp    = (ch_i == CH_LP);
        cls_o.is_rp    = (ch_i == CH_RP);
        cls_o.is_bad   = !(cls_o.is_digit || cls_o.is_op || cls_o.is_lp || cls_o.is_rp);
    end

endmodule

// File: rtl/expr_checker.sv
// Streaming syntax checker for ASCII arithmetic expressions: one char per
// valid cycle, registered "complete expression" flag and sticky error cause.
module expr_checker
    import expr_pkg::*;
#(
    parameter int MAX_DEPTH   = 7,
    parameter int MAX_DIGITS  = 4,
    parameter int ALLOW_MINUS = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [7:0] in,
    output logic       out,
    output logic       err,
    output logic [2:0] err_code,
    output logic [3:0] depth,
    output logic [7:0] opnd_cnt
);

    cclass_t    cls;
    state_t     st_q, st_d;
    logic [3:0] dep_q, dep_d;
    logic [3:0] dig_q, dig_d;
    logic [7:0] cnt_q, cnt_d;
    logic       out_q, out_d;
    logic       err_q;
    err_t       code_q, ecode;

    expr_char_class #(.ALLOW_MINUS(ALLOW_MINUS)) u_class (
        .ch_i  (in),
        .cls_o (cls)
    );

    // Next-state decode; an error leaves every counter at its current value.
    always_comb begin
        st_d  = st_q;
        dep_d = dep_q;
        dig_d = dig_q;
        cnt_d = cnt_q;
        ecode = E_NONE;
        if (st_q != S_ERR) begin
            if (cls.is_bad) begin
                ecode = E_BAD;
            end else begin
                case (st_q)
                    S_OPND: begin
                        if (cls.is_digit) begin
                            st_d  = S_NUM;
                            dig_d = 4'd1;
                            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        end else if (cls.is_lp) begin
                            if (dep_q == 4'(MAX_DEPTH)) ecode = E_DEPTH;
                            else                        dep_d = dep_q + 4'd1;
                        end else begin
                            ecode = E_TOKEN;
                        end
                    end
                    S_NUM: begin
                        if (cls.is_digit) begin
                            if (dig_q == 4'(MAX_DIGITS)) ecode = E_LONG;
                            else                         dig_d = dig_q + 4'd1;
                        end else if (cls.is_op) begin
                            st_d = S_OPND;
                        end else if (cls.is_rp) begin
                            if (dep_q == 4'd0) begin
                                ecode = E_UNMATCH;
                            end else begin
                                dep_d = dep_q - 4'd1;
                                st_d  = S_CLOSE;
                            end
                        end else begin
                            ecode = E_TOKEN;
                        end
                    end
                    S_CLOSE: begin
                        if (cls.is_op) begin
                            st_d = S_OPND;
                        end else if (cls.is_rp) begin
                            if (dep_q == 4'd0) ecode = E_UNMATCH;
                            else               dep_d = dep_q - 4'd1;
                        end else begin
                            ecode = E_TOKEN;
                        end
                    end
                    default: ;
                endcase
            end
            if (ecode != E_NONE) begin
                st_d  = S_ERR;
                dep_d = dep_q;
                dig_d = dig_q;
                cnt_d = cnt_q;
            end
        end
        out_d = ((st_d == S_NUM) || (st_d == S_CLOSE)) && (dep_d == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            st_q   <= S_OPND;
            dep_q  <= '0;
            dig_q  <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            err_q  <= 1'b0;
            code_q <= E_NONE;
        end else if (in_valid && (st_q != S_ERR)) begin
            st_q  <= st_d;
            dep_q <= dep_d;
            dig_q <= dig_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            if (ecode != E_NONE) begin
                err_q  <= 1'b1;
                code_q <= ecode;
            end
        end
    end

    assign out      = out_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign depth    = dep_q;
    assign opnd_cnt = cnt_q;

endmodule
